// File: rtl/rib_gpio_ctrl.sv
// rib_gpio_ctrl: parametrised GPIO peripheral on the RIB slave bus.
//   clk, rst           : single clock, asynchronous active-high reset
//   addr_i/data_i/...  : RIB request (addr_i[5:2] decoded, sel_i byte strobes)
//   data_o             : read data (0 for writes)
//   req_*/rsp_*        : valid/ready handshake, one transaction outstanding
//   io_pin_i           : raw asynchronous pad inputs
//   io_out_o/io_oe_o   : output data (OUT) and output enable (DIR)
//   int_sig_o          : registered OR of all pending interrupt bits
module rib_gpio_ctrl #(
    parameter int unsigned GPIO_NUM    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         data_i,
    input  logic [3:0]          sel_i,
    input  logic                we_i,
    output logic [31:0]         data_o,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    input  logic [GPIO_NUM-1:0] io_pin_i,
    output logic [GPIO_NUM-1:0] io_out_o,
    output logic [GPIO_NUM-1:0] io_oe_o,
    output logic                int_sig_o
);

    localparam int unsigned ArmW = $clog2(SYNC_STAGES + 2);
    localparam logic [ArmW-1:0] ArmMax = ArmW'(SYNC_STAGES + 1);

    logic [GPIO_NUM-1:0] r_dir, r_out, r_ie, r_itype, r_ipol, r_ip, r_prev;
    logic [GPIO_NUM-1:0] r_sync [SYNC_STAGES];
    logic                r_rsp_valid;
    logic                r_int;
    logic [31:0]         r_data;
    logic [ArmW-1:0]     r_arm_cnt;

    logic                w_accept, w_wr;
    logic [3:0]          w_off;
    logic [31:0]         w_bmask;
    logic [GPIO_NUM-1:0] w_wmask, w_wdata, w_in;
    logic                w_wr_dir, w_wr_out, w_wr_ie, w_wr_itype, w_wr_ipol;
    logic                w_wr_ip, w_wr_set, w_wr_clr;
    logic [GPIO_NUM-1:0] w_dir_d, w_out_d, w_ie_d, w_itype_d, w_ipol_d, w_ip_d;
    logic [GPIO_NUM-1:0] w_edge_set, w_w1c, w_level;
    logic                w_armed;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_accept = req_valid_i & ~r_rsp_valid;
    assign w_wr     = w_accept & we_i;
    assign w_off    = addr_i[5:2];
    assign w_bmask  = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign w_wmask  = w_bmask[GPIO_NUM-1:0];
    assign w_wdata  = data_i[GPIO_NUM-1:0] & w_wmask;
    assign w_in     = r_sync[SYNC_STAGES-1];
    assign w_armed  = (r_arm_cnt == ArmMax);
    assign w_unused = ^{addr_i[31:6], addr_i[1:0], data_i, w_bmask};

    assign w_wr_dir   = w_wr && (w_off == 4'h0);
    assign w_wr_out   = w_wr && (w_off == 4'h1);
    assign w_wr_ie    = w_wr && (w_off == 4'h3);
    assign w_wr_itype = w_wr && (w_off == 4'h4);
    assign w_wr_ipol  = w_wr && (w_off == 4'h5);
    assign w_wr_ip    = w_wr && (w_off == 4'h6);
    assign w_wr_set   = w_wr && (w_off == 4'h7);
    assign w_wr_clr   = w_wr && (w_off == 4'h8);

    always_comb begin
        w_dir_d   = w_wr_dir   ? ((r_dir   & ~w_wmask) | w_wdata) : r_dir;
        w_ie_d    = w_wr_ie    ? ((r_ie    & ~w_wmask) | w_wdata) : r_ie;
        w_itype_d = w_wr_itype ? ((r_itype & ~w_wmask) | w_wdata) : r_itype;
        w_ipol_d  = w_wr_ipol  ? ((r_ipol  & ~w_wmask) | w_wdata) : r_ipol;
        w_out_d   = r_out;
        if (w_wr_out) begin
            w_out_d = (r_out & ~w_wmask) | w_wdata;
        end else if (w_wr_set) begin
            w_out_d = r_out | w_wdata;
        end else if (w_wr_clr) begin
            w_out_d = r_out & ~w_wdata;
        end
    end

    // Edge set is ORed in after the W1C clear so a coincident edge wins.
    // A change of ITYPE or a disabled pin forces the bit to 0.
    always_comb begin
        w_edge_set = {GPIO_NUM{w_armed}} & (w_in ^ r_prev) & ~(w_in ^ r_ipol);
        w_w1c      = w_wr_ip ? w_wdata : '0;
        w_level    = ~(w_in ^ r_ipol);
        w_ip_d     = r_ie & ~(w_itype_d ^ r_itype) &
                     ((r_itype & (w_edge_set | (r_ip & ~w_w1c))) | (~r_itype & w_level));
    end

    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            4'h0:    w_rdata = 32'(r_dir);
            4'h1:    w_rdata = 32'(r_out);
            4'h2:    w_rdata = 32'(w_in);
            4'h3:    w_rdata = 32'(r_ie);
            4'h4:    w_rdata = 32'(r_itype);
            4'h5:    w_rdata = 32'(r_ipol);
            4'h6:    w_rdata = 32'(r_ip);
            default: w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir       <= '0;
            r_out       <= '0;
            r_ie        <= '0;
            r_itype     <= '0;
            r_ipol      <= '0;
            r_ip        <= '0;
            r_prev      <= '0;
            r_rsp_valid <= 1'b0;
            r_int       <= 1'b0;
            r_data      <= 32'h0;
            r_arm_cnt   <= '0;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_dir   <= w_dir_d;
            r_out   <= w_out_d;
            r_ie    <= w_ie_d;
            r_itype <= w_itype_d;
            r_ipol  <= w_ipol_d;
            r_ip    <= w_ip_d;
            r_int   <= |r_ip;
            r_prev  <= w_in;
            r_sync[0] <= io_pin_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            // Keeps edge detection off until the synchroniser holds real pin data.
            if (r_arm_cnt != ArmMax) begin
                r_arm_cnt <= r_arm_cnt + ArmW'(1);
            end
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_data      <= we_i ? 32'h0 : w_rdata;
            end else if (r_rsp_valid && rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign data_o      = r_data;
    assign rsp_valid_o = r_rsp_valid;
    assign req_ready_o = ~r_rsp_valid;
    assign io_out_o    = r_out;
    assign io_oe_o     = r_dir;
    assign int_sig_o   = r_int;

endmodule

// File: tb/tb_rib_gpio_ctrl.sv
// tb_rib_gpio_ctrl: directed self-checking bench for rib_gpio_ctrl (GPIO_NUM=8, SYNC_STAGES=2).
module tb_rib_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  sel = 4'hF;
    logic        we = 1'b0;
    logic [31:0] data_o;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1;
    logic [7:0]  io_pin = '0, io_out, io_oe;
    logic        int_sig;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rdv;

    rib_gpio_ctrl #(.GPIO_NUM(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (addr),
        .data_i      (wdata),
        .sel_i       (sel),
        .we_i        (we),
        .data_o      (data_o),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .io_pin_i    (io_pin),
        .io_out_o    (io_out),
        .io_oe_o     (io_oe),
        .int_sig_o   (int_sig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction; returns #1 after the response handshake edge.
    task automatic bus_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        int t;
        @(negedge clk);
        addr = a; wdata = d; we = w; sel = s; req_valid = 1'b1; rsp_ready = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rd = data_o;
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(a, 1'b1, d, 4'hF, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_xfer(a, 1'b0, 32'h0, 4'hF, v);
        chk(tag, v, exp);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_io_out", {24'b0, io_out}, 32'h0);
        chk("rst_io_oe", {24'b0, io_oe}, 32'h0);
        chk("rst_int", {31'b0, int_sig}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            rd_chk($sformatf("rd_reset_off%0d", i * 4), 32'(i * 4), 32'h0);
            chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
        end

        // Output path
        wr(32'h00, 32'hFF);
        chk("io_oe", {24'b0, io_oe}, 32'hFF);
        wr(32'h04, 32'hA5);
        chk("out_write", {24'b0, io_out}, 32'hA5);
        wr(32'h1C, 32'h0A);
        chk("out_set", {24'b0, io_out}, 32'hAF);
        wr(32'h20, 32'h81);
        chk("out_clr", {24'b0, io_out}, 32'h2E);
        bus_xfer(32'h04, 1'b1, 32'hFFFFFFFF, 4'b1110, rdv);
        chk("out_sel_masked", {24'b0, io_out}, 32'h2E);
        chk("wr_data_o_zero", rdv, 32'h0);
        rd_chk("rd_out", 32'h04, 32'h2E);
        rd_chk("rd_dir", 32'h00, 32'hFF);
        rd_chk("rd_set_wo", 32'h1C, 32'h0);

        // Edge interrupt on pin0, rising
        wr(32'h0C, 32'h01);
        wr(32'h10, 32'h01);
        wr(32'h14, 32'h01);
        @(negedge clk); io_pin[0] = 1'b1;
        @(negedge clk); chk("edge_ip_t1", {24'b0, dut.r_ip}, 32'h0);
        @(negedge clk); chk("edge_ip_t2", {24'b0, dut.r_ip}, 32'h0);
        @(negedge clk); chk("edge_ip_t3", {24'b0, dut.r_ip}, 32'h01);
        chk("edge_int_t3", {31'b0, int_sig}, 32'd0);
        @(negedge clk); chk("edge_int_t4", {31'b0, int_sig}, 32'd1);
        io_pin[0] = 1'b0;
        repeat (6) @(negedge clk);
        rd_chk("edge_ip_sticky", 32'h18, 32'h01);
        rd_chk("rd_in_low", 32'h08, 32'h0);
        wr(32'h18, 32'h01);
        chk("w1c_ip", {24'b0, dut.r_ip}, 32'h0);
        chk("w1c_int", {31'b0, int_sig}, 32'd0);

        // Level interrupt on pin1, active low
        wr(32'h0C, 32'h02);
        wr(32'h10, 32'h00);
        wr(32'h14, 32'h00);
        rd_chk("level_ip", 32'h18, 32'h02);
        wr(32'h18, 32'h02);
        rd_chk("level_w1c_noeffect", 32'h18, 32'h02);
        @(negedge clk); io_pin[1] = 1'b1;
        @(negedge clk); chk("level_t1", {24'b0, dut.r_ip}, 32'h02);
        @(negedge clk); chk("level_t2", {24'b0, dut.r_ip}, 32'h02);
        @(negedge clk); chk("level_t3", {24'b0, dut.r_ip}, 32'h00);
        rd_chk("rd_in_pin1", 32'h08, 32'h02);

        // Edge set in the same cycle as the W1C clear
        wr(32'h0C, 32'h01);
        wr(32'h10, 32'h01);
        wr(32'h14, 32'h01);
        chk("pre_race_ip", {24'b0, dut.r_ip}, 32'h0);
        @(negedge clk); io_pin[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr(32'h18, 32'h01);
        chk("race_set_wins", {24'b0, dut.r_ip}, 32'h01);

        // Response stall: second request must not be taken
        @(negedge clk);
        addr = 32'h00; we = 1'b0; sel = 4'hF; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        addr = 32'h04; we = 1'b1; wdata = 32'h00;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_data_o", data_o, 32'hFF);
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", {31'b0, rsp_valid}, 32'd0);
        chk("stall_no_write", {24'b0, io_out}, 32'h2E);

        // Reset in the middle of a pending response
        @(negedge clk);
        addr = 32'h00; we = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("pre_rst_int", {31'b0, int_sig}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("async_io_oe", {24'b0, io_oe}, 32'h0);
        chk("async_io_out", {24'b0, io_out}, 32'h0);
        chk("async_int", {31'b0, int_sig}, 32'd0);
        chk("async_ip", {24'b0, dut.r_ip}, 32'h0);
        io_pin = 8'hFF;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Pins high across reset must not raise edges after release
        wr(32'h10, 32'hFF);
        wr(32'h14, 32'hFF);
        wr(32'h0C, 32'hFF);
        repeat (5) @(negedge clk);
        chk("arm_ip", {24'b0, dut.r_ip}, 32'h0);
        chk("arm_int", {31'b0, int_sig}, 32'd0);
        rd_chk("post_rst_dir", 32'h00, 32'h0);
        rd_chk("post_rst_out", 32'h04, 32'h0);
        rd_chk("post_rst_in", 32'h08, 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
